// File: rtl/mat_switch_pkg.sv
// Shared types for the mat_switch rendezvous crossbar.
package mat_switch_pkg;

    localparam int unsigned SWITCH_WIDTH = 16;

    typedef logic [31:0] word_t;
    typedef word_t [SWITCH_WIDTH-1:0] vec_t;

    typedef enum logic {
        PORT_IDLE = 1'b0,
        PORT_ACK  = 1'b1
    } port_state_t;

endpackage

// File: rtl/mat_switch_port.sv
// Per-core handshake state: sender/receiver acknowledge FSMs and the sender stall timeout.
module mat_switch_port
    import mat_switch_pkg::*;
#(
    parameter int unsigned SWITCH_TIMEOUT = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic send_ready,
    input  logic match_as_sender,
    input  logic match_as_receiver,
    output logic send_ok,
    output logic recv_ready,
    output logic timeout
);

    localparam int unsigned CNT_W = (SWITCH_TIMEOUT == 0) ? 1 : $clog2(SWITCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SWITCH_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SWITCH_TIMEOUT == 0) ? 0 : SWITCH_TIMEOUT - 1);

    port_state_t send_state, send_next;
    port_state_t recv_state, recv_next;
    logic [CNT_W-1:0] stall_cnt;
    logic stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            send_state <= PORT_IDLE;
            recv_state <= PORT_IDLE;
        end else begin
            send_state <= send_next;
            recv_state <= recv_next;
        end
    end

    // ACK lasts exactly one cycle; the state itself masks the port from matching.
    always_comb begin
        send_next = send_state;
        recv_next = recv_state;
        case (send_state)
            PORT_IDLE: if (match_as_sender) send_next = PORT_ACK;
            PORT_ACK:  send_next = PORT_IDLE;
            default:   send_next = PORT_IDLE;
        endcase
        case (recv_state)
            PORT_IDLE: if (match_as_receiver) recv_next = PORT_ACK;
            PORT_ACK:  recv_next = PORT_IDLE;
            default:   recv_next = PORT_IDLE;
        endcase
    end

    assign send_ok    = (send_state == PORT_ACK);
    assign recv_ready = (recv_state == PORT_ACK);

    assign stall = send_ready && !match_as_sender && (send_state == PORT_IDLE);

    // Saturating stall counter; the flag is sticky until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            if (!send_ready || match_as_sender) begin
                stall_cnt <= '0;
            end else if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if ((SWITCH_TIMEOUT != 0) && stall && (stall_cnt == CNT_LAST)) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mat_switch.sv
// Rendezvous crossbar: sender s and receiver d that name each other transfer a vector s -> d.
module mat_switch
    import mat_switch_pkg::*;
#(
    parameter int unsigned SWITCH_CORE_SIZE      = 4,
    parameter int unsigned SWITCH_WIDTH          = 16,
    parameter int unsigned SWITCH_TIMEOUT        = 0,
    parameter int unsigned SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
    input  logic                                                      clock,
    input  logic                                                      reset,
    input  logic [SWITCH_CORE_SIZE-1:0]                               switch_send_ready,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]    switch_send_core_idx,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][31:0]       switch_send_data,
    output logic [SWITCH_CORE_SIZE-1:0]                               switch_send_ok,
    input  logic [SWITCH_CORE_SIZE-1:0]                               switch_recv_request,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]    switch_recv_core_idx,
    output logic [SWITCH_CORE_SIZE-1:0]                               switch_recv_ready,
    output logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][31:0]       switch_recv_data,
    output logic [SWITCH_CORE_SIZE-1:0]                               switch_timeout
);

    logic [SWITCH_CORE_SIZE-1:0] match_as_sender;
    logic [SWITCH_CORE_SIZE-1:0] match_as_receiver;
    logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][31:0] sel_data;

    // Mutual naming makes every match one-to-one, so no arbitration is needed.
    always_comb begin
        match_as_sender   = '0;
        match_as_receiver = '0;
        for (int s = 0; s < int'(SWITCH_CORE_SIZE); s++) begin
            for (int d = 0; d < int'(SWITCH_CORE_SIZE); d++) begin
                if (switch_send_ready[s] && !switch_send_ok[s] &&
                    (switch_send_core_idx[s] == SWITCH_CORE_ADDR_SIZE'(d)) &&
                    switch_recv_request[d] && !switch_recv_ready[d] &&
                    (switch_recv_core_idx[d] == SWITCH_CORE_ADDR_SIZE'(s))) begin
                    match_as_sender[s]   = 1'b1;
                    match_as_receiver[d] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int d = 0; d < int'(SWITCH_CORE_SIZE); d++) begin
            for (int s = 0; s < int'(SWITCH_CORE_SIZE); s++) begin
                if (switch_recv_core_idx[d] == SWITCH_CORE_ADDR_SIZE'(s)) begin
                    sel_data[d] = switch_send_data[s];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            switch_recv_data <= '0;
        end else begin
            for (int d = 0; d < int'(SWITCH_CORE_SIZE); d++) begin
                if (match_as_receiver[d]) begin
                    switch_recv_data[d] <= sel_data[d];
                end
            end
        end
    end

    for (genvar i = 0; i < int'(SWITCH_CORE_SIZE); i++) begin : g_port
        mat_switch_port #(
            .SWITCH_TIMEOUT(SWITCH_TIMEOUT)
        ) u_port (
            .clock            (clock),
            .reset            (reset),
            .send_ready       (switch_send_ready[i]),
            .match_as_sender  (match_as_sender[i]),
            .match_as_receiver(match_as_receiver[i]),
            .send_ok          (switch_send_ok[i]),
            .recv_ready       (switch_recv_ready[i]),
            .timeout          (switch_timeout[i])
        );
    end

endmodule
